// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet TX path: FSM states, stream width
// and the fixed source slots used by the TX arbiter.
package eth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        GAP  = 2'd2
    } state_e;

    localparam int ETH_AXIS_DATA_W = 32;

    localparam int SRC_ARP  = 0;
    localparam int SRC_ICMP = 1;
    localparam int SRC_UDP  = 2;

endpackage

// File: rtl/eth_tx_arb_if.sv
// AXI-Stream bundle between the per-protocol TX sources, the arbiter and the MAC.
// The master modport is the arbiter's view; slave is the surrounding sources/MAC.
interface eth_tx_arb_if
    import eth_pkg::*;
#(
    parameter int NUM_SRC = 3,
    parameter int DATA_W  = ETH_AXIS_DATA_W
);

    logic [NUM_SRC*DATA_W-1:0] s_axis_tdata;
    logic [NUM_SRC-1:0]        s_axis_tvalid;
    logic [NUM_SRC-1:0]        s_axis_tlast;
    logic [NUM_SRC-1:0]        s_axis_tready;

    logic [DATA_W-1:0]         m_axis_tdata;
    logic                      m_axis_tvalid;
    logic                      m_axis_tlast;
    logic                      m_axis_tready;

    modport master (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
    );

    modport slave (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request after last_grant_i, scanning
// upward and wrapping explicitly at NUM_REQ-1 so unused index codes are never visited.
module rr_arbiter #(
    parameter  int NUM_REQ = 3,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_grant_i,
    output logic [IDX_W-1:0]   grant_o,
    output logic               grant_vld_o
);

    always_comb begin
        int cand;
        // NOTE: every output and temporary gets a default before any branch,
        // otherwise paths that skip an assignment infer a latch.
        cand        = 0;
        grant_o     = '0;
        grant_vld_o = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = int'(last_grant_i) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!grant_vld_o && req_i[cand[IDX_W-1:0]]) begin
                grant_o     = cand[IDX_W-1:0];
                grant_vld_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/eth_tx_arb.sv
// Packet-granular round-robin arbiter sharing the MAC TX stream between sources;
// a grant is held from first beat to tlast and followed by an inter-packet gap.
module eth_tx_arb
    import eth_pkg::*;
#(
    parameter  int NUM_SRC    = 3,
    parameter  int DATA_W     = ETH_AXIS_DATA_W,
    parameter  int IFG_CYCLES = 3,
    localparam int IDX_W      = $clog2(NUM_SRC)
) (
    input  logic             aclk,
    input  logic             aresetn,
    eth_tx_arb_if.master     axis,
    output logic [IDX_W-1:0] grant_id,
    output logic             busy,
    output logic [15:0]      pkt_cnt
);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [7:0]       gap_q, gap_d;
    logic [15:0]      pkt_cnt_q, pkt_cnt_d;

    logic [IDX_W-1:0] arb_grant;
    logic             arb_vld;
    logic             beat_vld, beat_last;

    rr_arbiter #(
        .NUM_REQ (NUM_SRC)
    ) u_rr (
        .req_i        (axis.s_axis_tvalid),
        .last_grant_i (last_q),
        .grant_o      (arb_grant),
        .grant_vld_o  (arb_vld)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of process ordering.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            last_q    <= IDX_W'(NUM_SRC - 1);
            gap_q     <= '0;
            pkt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            gap_q     <= gap_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        gap_d     = gap_q;
        pkt_cnt_d = pkt_cnt_q;

        beat_vld  = axis.s_axis_tvalid[grant_q];
        beat_last = axis.s_axis_tlast[grant_q];

        // Data is muxed unconditionally; only the qualifiers depend on state.
        axis.m_axis_tdata  = axis.s_axis_tdata[int'(grant_q)*DATA_W +: DATA_W];
        axis.m_axis_tvalid = 1'b0;
        axis.m_axis_tlast  = 1'b0;
        axis.s_axis_tready = '0;

        unique case (state_q)
            IDLE: begin
                if (arb_vld) begin
                    grant_d = arb_grant;
                    last_d  = arb_grant;
                    state_d = XFER;
                end
            end
            XFER: begin
                axis.m_axis_tvalid          = beat_vld;
                axis.m_axis_tlast           = beat_last;
                axis.s_axis_tready[grant_q] = axis.m_axis_tready;
                if (beat_vld && beat_last && axis.m_axis_tready) begin
                    pkt_cnt_d = pkt_cnt_q + 16'd1;
                    if (IFG_CYCLES > 0) begin
                        gap_d   = 8'(IFG_CYCLES);
                        state_d = GAP;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            GAP: begin
                gap_d = gap_q - 8'd1;
                if (gap_q <= 8'd1) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign grant_id = grant_q;
    assign busy     = (state_q != IDLE);
    assign pkt_cnt  = pkt_cnt_q;

endmodule

// File: tb/tb_eth_tx_arb.sv
// Self-checking bench for eth_tx_arb: per-source packet queues drive the inputs,
// expected MAC beats sit in a scoreboard queue and are compared as they leave.
module tb_eth_tx_arb;
    import eth_pkg::*;

    localparam int NS  = 3;
    localparam int DW  = ETH_AXIS_DATA_W;
    localparam int IFG = 3;
    localparam int IW  = $clog2(NS);

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [IW-1:0] grant_id;
    logic          busy;
    logic [15:0]   pkt_cnt;

    eth_tx_arb_if #(.NUM_SRC(NS), .DATA_W(DW)) axis ();

    eth_tx_arb #(
        .NUM_SRC    (NS),
        .DATA_W     (DW),
        .IFG_CYCLES (IFG)
    ) dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .axis     (axis),
        .grant_id (grant_id),
        .busy     (busy),
        .pkt_cnt  (pkt_cnt)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic [IW-1:0] src;
    } exp_t;

    typedef struct {
        int          src;
        int          len;
        logic [31:0] d0;
        int          exp_grant;
        int          exp_cnt;
    } vec_t;

    beat_t src_q [NS][$];
    exp_t  exp_q [$];
    int    gap_log [$];
    bit    mready_pat [$];
    bit    mready_def = 1'b1;
    int    pause [NS];

    int n_chk = 0, n_pass = 0, viol = 0, cyc = 0;
    int rise_cyc = -1, first_hs = -1, gap_len = 0;
    bit in_gap = 1'b0, prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    logic          snap_tvalid, snap_busy;
    logic [IW-1:0] snap_grant;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Queue a packet on a source and the matching beats in the scoreboard.
    task automatic load_pkt(input int src, input int len, input logic [31:0] d0);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.data = d0 + 32'(k);
            b.last = (k == len - 1);
            src_q[src].push_back(b);
        end
    endtask

    task automatic push_exp(input int src, input int len, input logic [31:0] d0);
        exp_t e;
        for (int k = 0; k < len; k++) begin
            e.data = d0 + 32'(k);
            e.last = (k == len - 1);
            e.src  = IW'(src);
            exp_q.push_back(e);
        end
    endtask

    // One clock: observe at the falling edge, update sources just after the rising edge.
    task automatic cycle();
        bit   hs [NS];
        exp_t e;
        logic was;
        @(negedge aclk);
        cyc++;
        snap_tvalid = axis.m_axis_tvalid;
        snap_busy   = busy;
        snap_grant  = grant_id;

        for (int i = 0; i < NS; i++) begin
            if (axis.s_axis_tready[i] &&
                !(exp_q.size() > 0 && int'(exp_q[0].src) == i && axis.m_axis_tready))
                viol++;
            hs[i] = axis.s_axis_tvalid[i] && axis.s_axis_tready[i];
        end

        if (axis.m_axis_tvalid && exp_q.size() > 0)
            check("tready_mirror", 64'(axis.s_axis_tready[exp_q[0].src]), 64'(axis.m_axis_tready));

        if (prev_stall && axis.m_axis_tvalid) begin
            check("stall_data", 64'(axis.m_axis_tdata), 64'(prev_data));
            check("stall_last", 64'(axis.m_axis_tlast), 64'(prev_last));
        end
        prev_stall = axis.m_axis_tvalid && !axis.m_axis_tready;
        prev_data  = axis.m_axis_tdata;
        prev_last  = axis.m_axis_tlast;

        if (in_gap) begin
            if (axis.m_axis_tvalid) begin
                gap_log.push_back(gap_len);
                in_gap = 1'b0;
            end else begin
                gap_len++;
            end
        end

        if (axis.m_axis_tvalid && axis.m_axis_tready) begin
            if (first_hs < 0) first_hs = cyc;
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_beat: got data 0x%0h, expected no beat", axis.m_axis_tdata);
            end else begin
                e = exp_q.pop_front();
                check("beat_data", 64'(axis.m_axis_tdata), 64'(e.data));
                check("beat_last", 64'(axis.m_axis_tlast), 64'(e.last));
                check("beat_grant", 64'(grant_id), 64'(e.src));
            end
            if (axis.m_axis_tlast) begin
                in_gap  = 1'b1;
                gap_len = 0;
            end
        end

        @(posedge aclk);
        #1;
        for (int i = 0; i < NS; i++) begin
            if (hs[i]) void'(src_q[i].pop_front());
        end
        axis.m_axis_tready = (mready_pat.size() > 0) ? mready_pat.pop_front() : mready_def;
        for (int i = 0; i < NS; i++) begin
            was = axis.s_axis_tvalid[i];
            if (pause[i] > 0) begin
                axis.s_axis_tvalid[i] = 1'b0;
                pause[i]--;
            end else if (src_q[i].size() > 0) begin
                axis.s_axis_tvalid[i]            = 1'b1;
                axis.s_axis_tdata[i*DW +: DW]    = src_q[i][0].data;
                axis.s_axis_tlast[i]             = src_q[i][0].last;
            end else begin
                axis.s_axis_tvalid[i] = 1'b0;
                axis.s_axis_tlast[i]  = 1'b0;
            end
            if (!was && axis.s_axis_tvalid[i]) rise_cyc = cyc;
        end
    endtask

    task automatic run_until_idle(input int budget, input string name);
        int n;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!(exp_q.size() == 0 && !snap_busy) && n < budget);
        if (exp_q.size() != 0 || snap_busy) begin
            n_chk++;
            $display("FAIL %s_timeout: %0d beats outstanding after %0d cycles, expected 0",
                     name, exp_q.size(), budget);
        end
    endtask

    task automatic run_until_left(input int left, input int budget, input string name);
        int n;
        n = 0;
        while (exp_q.size() > left && n < budget) begin
            cycle();
            n++;
        end
        if (exp_q.size() > left) begin
            n_chk++;
            $display("FAIL %s_timeout: %0d beats outstanding, expected %0d", name, exp_q.size(), left);
        end
    endtask

    task automatic pulse_reset();
        aresetn = 1'b0;
        cycle();
        aresetn = 1'b1;
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation still running at 200us, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [4];
        tbl[0] = '{SRC_ICMP, 4, 32'h11,  SRC_ICMP, 1};
        tbl[1] = '{SRC_UDP,  1, 32'hA0,  SRC_UDP,  2};
        tbl[2] = '{SRC_ARP,  3, 32'h200, SRC_ARP,  3};
        tbl[3] = '{SRC_ARP,  2, 32'h300, SRC_ARP,  4};

        axis.s_axis_tdata  = '0;
        axis.s_axis_tvalid = '0;
        axis.s_axis_tlast  = '0;
        axis.m_axis_tready = 1'b1;
        for (int i = 0; i < NS; i++) pause[i] = 0;

        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        check("rst_m_tvalid", 64'(axis.m_axis_tvalid), 64'd0);
        check("rst_m_tlast",  64'(axis.m_axis_tlast),  64'd0);
        check("rst_s_tready", 64'(axis.s_axis_tready), 64'd0);
        check("rst_busy",     64'(busy),               64'd0);
        check("rst_grant",    64'(grant_id),           64'd0);
        check("rst_pkt_cnt",  64'(pkt_cnt),            64'd0);

        // Single-source packets, one at a time; first beat lands two monitor
        // cycles after the source raises tvalid (one arbitration cycle).
        for (int v = 0; v < 4; v++) begin
            load_pkt(tbl[v].src, tbl[v].len, tbl[v].d0);
            push_exp(tbl[v].src, tbl[v].len, tbl[v].d0);
            first_hs = -1;
            rise_cyc = -1;
            run_until_idle(100, "single");
            check("first_beat_latency", 64'(first_hs - rise_cyc), 64'd2);
            check("tbl_grant",   64'(grant_id), 64'(tbl[v].exp_grant));
            check("tbl_pkt_cnt", 64'(pkt_cnt),  64'(tbl[v].exp_cnt));
        end
        check("non_granted_ready", 64'(viol), 64'd0);

        // All sources requesting from reset: source 0 first, then rotation.
        pulse_reset();
        gap_log.delete();
        in_gap = 1'b0;
        load_pkt(SRC_ARP,  2, 32'hA00);
        load_pkt(SRC_ARP,  2, 32'hA10);
        load_pkt(SRC_ICMP, 2, 32'hB00);
        load_pkt(SRC_UDP,  2, 32'hC00);
        push_exp(SRC_ARP,  2, 32'hA00);
        push_exp(SRC_ICMP, 2, 32'hB00);
        push_exp(SRC_UDP,  2, 32'hC00);
        push_exp(SRC_ARP,  2, 32'hA10);
        run_until_idle(200, "rotate");
        check("rotate_pkt_cnt", 64'(pkt_cnt), 64'd4);
        check("gap_count", 64'(gap_log.size()), 64'd3);
        for (int g = 0; g < gap_log.size(); g++)
            check("gap_len", 64'(gap_log[g]), 64'(IFG + 1));

        // Source 2 under MAC backpressure.
        for (int k = 0; k < 24; k++) mready_pat.push_back(k % 3 == 0);
        load_pkt(SRC_UDP, 4, 32'hD0);
        push_exp(SRC_UDP, 4, 32'hD0);
        run_until_idle(200, "stall");
        mready_pat.delete();
        check("stall_pkt_cnt", 64'(pkt_cnt),  64'd5);
        check("stall_grant",   64'(grant_id), 64'd2);

        // Source 0 bubbles mid-packet while source 1 waits; last grant was 2, so 0 wins.
        load_pkt(SRC_ARP,  5, 32'hE0);
        load_pkt(SRC_ICMP, 2, 32'hF0);
        push_exp(SRC_ARP,  5, 32'hE0);
        push_exp(SRC_ICMP, 2, 32'hF0);
        run_until_left(5, 50, "bubble_pre");
        pause[SRC_ARP] = 2;
        cycle();
        cycle();
        check("bubble_tvalid", 64'(snap_tvalid), 64'd0);
        check("bubble_grant",  64'(snap_grant),  64'd0);
        run_until_idle(200, "bubble");
        check("bubble_pkt_cnt", 64'(pkt_cnt),  64'd7);
        check("bubble_next",    64'(grant_id), 64'd1);

        // Reset during beat 2 of 5 with source 0 still holding tvalid.
        load_pkt(SRC_ARP, 5, 32'h500);
        push_exp(SRC_ARP, 5, 32'h500);
        run_until_left(4, 50, "midrst_pre");
        mready_def         = 1'b0;
        axis.m_axis_tready = 1'b0;
        pulse_reset();
        check("midrst_m_tvalid", 64'(axis.m_axis_tvalid), 64'd0);
        check("midrst_m_tlast",  64'(axis.m_axis_tlast),  64'd0);
        check("midrst_s_tready", 64'(axis.s_axis_tready), 64'd0);
        check("midrst_busy",     64'(busy),               64'd0);
        check("midrst_pkt_cnt",  64'(pkt_cnt),            64'd0);
        check("midrst_grant",    64'(grant_id),           64'd0);
        src_q[SRC_ARP].delete();
        exp_q.delete();
        in_gap     = 1'b0;
        prev_stall = 1'b0;
        mready_def = 1'b1;
        load_pkt(SRC_ARP, 2, 32'h600);
        push_exp(SRC_ARP, 2, 32'h600);
        run_until_idle(100, "post_rst");
        check("post_rst_pkt_cnt", 64'(pkt_cnt),  64'd1);
        check("post_rst_grant",   64'(grant_id), 64'd0);

        // Packet counter wrap from 65535.
        force dut.pkt_cnt_q = 16'hFFFF;
        #1;
        release dut.pkt_cnt_q;
        load_pkt(SRC_ICMP, 1, 32'h777);
        push_exp(SRC_ICMP, 1, 32'h777);
        run_until_idle(100, "wrap");
        check("wrap_pkt_cnt", 64'(pkt_cnt),  64'd0);
        check("wrap_grant",   64'(grant_id), 64'd1);

        check("non_granted_ready_all", 64'(viol), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/eth_tx_arb.md
Name: eth_tx_arb

Overview:
- Packet-granular round-robin arbiter that shares the single 32-bit MAC TX AXI-Stream between several packet sources.
- Typical sources: ARP reply, ICMP echo, UDP payload/header path.
- Sits between the per-protocol TX builders/FIFOs and the MAC TX interface.
- Holds a grant from first beat to tlast and enforces a minimum inter-packet idle gap.

Parameters:
- NUM_SRC, 3, number of requesting sources (2..8).
- DATA_W, 32, stream data width.
- IFG_CYCLES, 3, extra idle cycles inserted after each packet (0..255).

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset, synchronous, active-low.
- s_axis_tdata  in  NUM_SRC*DATA_W  source data; source i occupies bits [i*DATA_W +: DATA_W].
- s_axis_tvalid  in  NUM_SRC  per-source valid.
- s_axis_tlast  in  NUM_SRC  per-source last.
- s_axis_tready  out  NUM_SRC  per-source ready.
- m_axis_tdata  out  DATA_W  to MAC.
- m_axis_tvalid  out  1  to MAC.
- m_axis_tlast  out  1  to MAC.
- m_axis_tready  in  1  from MAC.
- grant_id  out  $clog2(NUM_SRC)  index of the current or last granted source.
- busy  out  1  high in XFER and GAP.
- pkt_cnt  out  16  packets forwarded; wraps at 65535 -> 0.

Behaviour:
- Clocking and reset:
  - All state is on posedge aclk.
  - When aresetn=0: state=IDLE, grant_id=0, last_grant=NUM_SRC-1 (source 0 wins first), gap counter=0, pkt_cnt=0.
  - Also at reset: all s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, busy=0.
- State machine:
  - IDLE:
    - If no s_axis_tvalid bit is set, stay.
    - Otherwise register the winner as the first requesting index scanning last_grant+1, last_grant+2, ... modulo NUM_SRC.
    - Load it into grant_id and last_grant, then go to XFER.
    - Arbitration latency: the first beat can be accepted one cycle after tvalid is seen.
  - XFER (combinational mux on registered grant g):
    - m_axis_tdata = s_axis_tdata[g], m_axis_tvalid = s_axis_tvalid[g], m_axis_tlast = s_axis_tlast[g].
    - s_axis_tready[g] = m_axis_tready; all other tready bits are 0.
    - On a handshake with tlast=1: pkt_cnt+1; go to GAP (load counter = IFG_CYCLES) if IFG_CYCLES>0, else IDLE.
  - GAP:
    - Outputs idle (tvalid=0, all tready=0).
    - Decrement the counter each cycle; go to IDLE when it reaches 1.
- Gap rules:
  - Between two packets m_axis_tvalid is low for exactly IFG_CYCLES+1 cycles minimum: GAP cycles plus the IDLE arbitration cycle.
  - This holds even when the same source requests back-to-back.
- Boundary conditions:
  - Granted source drops tvalid mid-packet: stay in XFER, m_axis_tvalid=0 (bubble). The grant is never revoked before tlast.
  - m_axis_tready held low: data and tlast held stable through the mux. No beats are lost or duplicated.
  - Single-beat packet (tvalid and tlast on the first beat): legal, and counts as a packet.
  - Non-granted sources are never acknowledged; their valid may stay asserted indefinitely.
  - All sources requesting continuously: grants rotate 0,1,2,0,... with no starvation.
  - Reset mid-packet: immediate return to IDLE, m_axis_tvalid drops. The partial frame is the MAC's concern; pkt_cnt is not incremented.
  - NUM_SRC not a power of two: the rotation pointer wraps explicitly at NUM_SRC-1, never through unused codes.

Decomposition:
- Shared package eth_pkg holds:
  - the state typedef (IDLE, XFER, GAP);
  - ETH_AXIS_DATA_W=32;
  - source index constants SRC_ARP=0, SRC_ICMP=1, SRC_UDP=2.
- One natural sub-module: rr_arbiter, a combinational round-robin priority pick from a request vector and last_grant, producing a winner index and a valid flag. It is reusable elsewhere.
- The FSM, mux and counters stay in eth_tx_arb.

Test Plan:
- Source 1 only, 4-beat packet 0x11..0x14, m_tready=1 -> grant_id=1; m_axis sees 4 beats one cycle after valid; tlast on 0x14; pkt_cnt=1; tready[0],[2] stay 0.
- Sources 0,1,2 all valid from reset, 2-beat packets each, IFG_CYCLES=3 -> output order src0,src1,src2,src0; tvalid low exactly 4 cycles between packets.
- Source 2 in XFER, m_tready toggles 1,0,0,1 -> tdata/tlast stable while stalled; each word appears once; s_axis_tready[2] mirrors m_tready.
- Granted source 0 drops tvalid for 2 cycles mid-packet while source 1 is valid -> grant stays 0 until tlast; source 1 is served next.
- aresetn low for 1 cycle during beat 2 of 5 -> all outputs at reset values the next cycle; pkt_cnt=0; the next request from source 0 is granted normally.
- Preload pkt_cnt to 65535, forward one packet -> pkt_cnt=0.
